// File: rtl/obs_trace_capture_if.sv
// Capture-side bus of obs_trace_capture: arm/stop control, observation strobe,
// the sampled DUT bus and the trace drain stream with its status outputs.
interface obs_trace_capture_if #(
  parameter int DATA_W  = 8,
  parameter int STAMP_W = 32,
  parameter int DEPTH   = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                       start;
  logic                       stop;
  logic                       obs;
  logic [DATA_W-1:0]          data_in;
  logic                       trace_valid;
  logic                       trace_ready;
  logic [STAMP_W+DATA_W-1:0]  trace_data;
  logic [LVL_W-1:0]           fifo_level;
  logic [15:0]                sample_cnt;
  logic [15:0]                drop_cnt;
  logic [1:0]                 state;
  logic                       done;

  modport master (
    output start, stop, obs, data_in, trace_ready,
    input  trace_valid, trace_data, fifo_level, sample_cnt, drop_cnt, state, done
  );

  modport slave (
    input  start, stop, obs, data_in, trace_ready,
    output trace_valid, trace_data, fifo_level, sample_cnt, drop_cnt, state, done
  );
endinterface

// File: rtl/obs_trace_capture.sv
// Stamps and buffers DUT output samples taken on the observation strobe, then
// drains them over a valid/ready stream; one arm/stop run yields one trace.
module obs_trace_capture #(
  parameter int DATA_W      = 8,
  parameter int STAMP_W     = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_SAMPLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  obs_trace_capture_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = STAMP_W + DATA_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [31:0]      MAX_U    = 32'(MAX_SAMPLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [15:0]        sample_cnt_q, sample_cnt_d, drop_cnt_q, drop_cnt_d;
  logic               done_q, done_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               capturing_s, pop_s, push_s, drop_s, cap_limit_s;
  logic [15:0]        sample_inc_s, drop_inc_s;

  // Handshake decode; a full FIFO still accepts a push when the head leaves.
  always_comb begin
    capturing_s  = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    pop_s        = (level_q != {LVL_W{1'b0}}) && bus.trace_ready;
    push_s       = capturing_s && bus.obs && ((level_q != FULL_LVL) || pop_s);
    drop_s       = capturing_s && bus.obs && !push_s;
    sample_inc_s = (push_s && (sample_cnt_q != 16'hFFFF)) ? sample_cnt_q + 16'd1 : sample_cnt_q;
    drop_inc_s   = (drop_s && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    cap_limit_s  = {16'd0, sample_inc_s} >= MAX_U;
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Run control; the start cycle itself is stamp 0, so the next cycle is 1.
  always_comb begin
    state_d      = state_q;
    stamp_d      = stamp_q;
    sample_cnt_d = sample_inc_s;
    drop_cnt_d   = drop_inc_s;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_ARMED;
          stamp_d      = STAMP_W'(1);
          sample_cnt_d = 16'd0;
          drop_cnt_d   = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED, S_CAPTURE: begin
        stamp_d = stamp_q + STAMP_W'(1);
        if (bus.stop || cap_limit_s) begin
          state_d = S_DRAIN;
        end else if (bus.obs) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = state_q;
        end
      end
      S_DRAIN: begin
        if (level_q == {LVL_W{1'b0}}) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      stamp_q      <= {STAMP_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      level_q      <= {LVL_W{1'b0}};
      sample_cnt_q <= 16'd0;
      drop_cnt_q   <= 16'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stamp_q      <= stamp_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      done_q       <= done_d;
    end
  end

  // Sample storage; unreset because the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {stamp_q, bus.data_in};
    end
  end

  assign bus.trace_valid = (level_q != {LVL_W{1'b0}});
  assign bus.trace_data  = bus.trace_valid ? mem_q[rd_ptr_q] : {ENT_W{1'b0}};
  assign bus.fifo_level  = level_q;
  assign bus.sample_cnt  = sample_cnt_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.state       = state_q;
  assign bus.done        = done_q;
endmodule
